// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination-lock controller.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
//   state_t       : sequencer states
//   KEY_W         : bits per stored digit
//   NUM_KEYS      : number of push-buttons
//   onehot_to_idx : key vector -> {valid, idx}; valid only for exactly one bit set
package combo_lock_pkg;

  localparam int KEY_W    = 2;
  localparam int NUM_KEYS = 4;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    OPEN    = 3'd1,
    PROG    = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // idx is the position of the highest set bit; it is only meaningful when
  // valid (exactly one bit set) is returned high.
  function automatic logic [KEY_W:0] onehot_to_idx(input logic [NUM_KEYS-1:0] keys);
    logic [KEY_W-1:0] idx;
    int               ones;
    idx  = '0;
    ones = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        idx  = KEY_W'(i);
        ones = ones + 1;
      end
    end
    return {(ones == 1), idx};
  endfunction

endpackage

// File: rtl/combo_lock_controller_if.sv
// Bundle of the lock controller's key inputs and status outputs.
// Latency: n/a (wires only).
// Backpressure: none; key/relock are single-cycle pulses, prog_en is a level.
//   master : drives key_pulse, relock, prog_en; observes the status outputs
//   slave  : the controller; consumes the inputs, drives unlocked, error,
//            locked_out, digit_count, tries_left
interface combo_lock_controller_if #(
  parameter int CODE_LEN  = 4,
  parameter int MAX_TRIES = 3
);
  import combo_lock_pkg::*;

  localparam int DC_W = $clog2(CODE_LEN + 1);
  localparam int TL_W = $clog2(MAX_TRIES + 1);

  logic [NUM_KEYS-1:0] key_pulse;
  logic                relock;
  logic                prog_en;
  logic                unlocked;
  logic                error;
  logic                locked_out;
  logic [DC_W-1:0]     digit_count;
  logic [TL_W-1:0]     tries_left;

  modport master (
    output key_pulse, relock, prog_en,
    input  unlocked, error, locked_out, digit_count, tries_left
  );

  modport slave (
    input  key_pulse, relock, prog_en,
    output unlocked, error, locked_out, digit_count, tries_left
  );

endinterface

// File: rtl/lockout_timer.sv
// One-shot down-counter timing the lockout period.
// Latency: done pulses CYCLES cycles after the edge that samples start.
// Backpressure: none; a new start reloads the counter at any time.
//   Clock  in  : system clock
//   Resetn in  : async active-low reset
//   start  in  : load CYCLES-1 and begin counting
//   done   out : one-cycle pulse while the running counter sits at 0
module lockout_timer #(
  parameter int CYCLES = 150_000_000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic start,
  output logic done
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      cnt_q <= CNT_W'(CYCLES - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/combo_lock_controller.sv
// Combination-lock sequencer: matches key presses against the stored code,
// counts failed attempts, enforces a timed lockout and allows reprogramming.
// Latency: 1 cycle, all outputs registered. Backpressure: none, a press is
// consumed (or deliberately ignored) in the cycle it arrives.
//   Clock, Resetn : system clock, async active-low reset
//   bus (slave)   : key_pulse/relock/prog_en in; unlocked, error, locked_out,
//                   digit_count, tries_left out
module combo_lock_controller
  import combo_lock_pkg::*;
#(
  parameter int                        CODE_LEN       = 4,
  parameter logic [KEY_W*CODE_LEN-1:0] INIT_CODE      = 8'b11100100,
  parameter int                        MAX_TRIES      = 3,
  parameter int                        LOCKOUT_CYCLES = 150_000_000
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  combo_lock_controller_if.slave  bus
);

  localparam int DC_W  = $clog2(CODE_LEN + 1);
  localparam int TL_W  = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(CODE_LEN);

  localparam logic [DC_W-1:0] LAST_DIGIT = DC_W'(CODE_LEN - 1);
  localparam logic [TL_W-1:0] TRIES_INIT = TL_W'(MAX_TRIES);
  localparam logic [TL_W-1:0] TRIES_ONE  = TL_W'(1);

  // digit i occupies bits [2i+1:2i], i.e. element i of the packed array
  typedef logic [CODE_LEN-1:0][KEY_W-1:0] code_t;

  state_t          state_q;
  code_t           code_q;
  code_t           shadow_q;
  code_t           shadow_d;
  logic            mismatch_q;
  logic [DC_W-1:0] digit_count_q;
  logic [TL_W-1:0] tries_left_q;
  logic            unlocked_q;
  logic            error_q;
  logic            locked_out_q;

  logic [KEY_W:0]   press_dec;
  logic             press_vld;
  logic             press_any;
  logic [KEY_W-1:0] press_idx;
  logic [IDX_W-1:0] slot;
  logic             digit_miss;
  logic             timer_start;
  logic             timer_done;

  assign press_dec = onehot_to_idx(bus.key_pulse);
  assign press_vld = press_dec[KEY_W];
  assign press_idx = press_dec[KEY_W-1:0];
  assign press_any = |bus.key_pulse;

  // digit_count stays below CODE_LEN in ENTRY/PROG, so it addresses a digit directly
  assign slot = digit_count_q[IDX_W-1:0];

  // A multi-key press always counts as a wrong digit.
  assign digit_miss = !press_vld || (press_idx != code_q[slot]);

  // Shadow with the current press merged in, so the final digit can be
  // committed to code_q in the same edge as the earlier ones.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_d[slot] = press_idx;
  end

  // The last allowed failure starts the lockout timer as FAIL is left.
  assign timer_start = (state_q == FAIL) &&
                       ((tries_left_q == TRIES_ONE) || (tries_left_q == '0));

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .Clock  (Clock),
    .Resetn (Resetn),
    .start  (timer_start),
    .done   (timer_done)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= ENTRY;
      code_q        <= INIT_CODE;
      shadow_q      <= '0;
      mismatch_q    <= 1'b0;
      digit_count_q <= '0;
      tries_left_q  <= TRIES_INIT;
      unlocked_q    <= 1'b0;
      error_q       <= 1'b0;
      locked_out_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        ENTRY: begin
          if (bus.relock) begin
            digit_count_q <= '0;
            mismatch_q    <= 1'b0;
          end else if (press_any) begin
            if (digit_count_q == LAST_DIGIT) begin
              digit_count_q <= '0;
              mismatch_q    <= 1'b0;
              if (mismatch_q || digit_miss) begin
                state_q <= FAIL;
                error_q <= 1'b1;
              end else begin
                state_q      <= OPEN;
                unlocked_q   <= 1'b1;
                tries_left_q <= TRIES_INIT;
              end
            end else begin
              digit_count_q <= digit_count_q + DC_W'(1);
              mismatch_q    <= mismatch_q | digit_miss;
            end
          end
        end

        OPEN: begin
          tries_left_q <= TRIES_INIT;
          if (bus.relock) begin
            state_q    <= ENTRY;
            unlocked_q <= 1'b0;
          end else if (press_vld && bus.prog_en) begin
            state_q       <= PROG;
            shadow_q[0]   <= press_idx;
            digit_count_q <= DC_W'(1);
          end
        end

        PROG: begin
          // Aborting leaves code_q untouched; the partial shadow is simply
          // overwritten by the next programming run.
          if (bus.relock) begin
            state_q       <= ENTRY;
            unlocked_q    <= 1'b0;
            digit_count_q <= '0;
          end else if (!bus.prog_en) begin
            state_q       <= OPEN;
            digit_count_q <= '0;
          end else if (press_vld) begin
            if (digit_count_q == LAST_DIGIT) begin
              code_q        <= shadow_d;
              digit_count_q <= '0;
              state_q       <= OPEN;
            end else begin
              shadow_q      <= shadow_d;
              digit_count_q <= digit_count_q + DC_W'(1);
            end
          end
        end

        FAIL: begin
          if (tries_left_q != '0) begin
            tries_left_q <= tries_left_q - TL_W'(1);
          end
          if (timer_start) begin
            state_q      <= LOCKOUT;
            locked_out_q <= 1'b1;
          end else begin
            state_q <= ENTRY;
          end
        end

        LOCKOUT: begin
          if (timer_done) begin
            state_q      <= ENTRY;
            locked_out_q <= 1'b0;
            tries_left_q <= TRIES_INIT;
          end
        end

        default: begin
          state_q       <= ENTRY;
          unlocked_q    <= 1'b0;
          locked_out_q  <= 1'b0;
          digit_count_q <= '0;
          mismatch_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.error       = error_q;
  assign bus.locked_out  = locked_out_q;
  assign bus.digit_count = digit_count_q;
  assign bus.tries_left  = tries_left_q;

endmodule

// File: tb/tb_combo_lock_controller.sv
// Self-checking bench for combo_lock_controller with a sequence-level model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_combo_lock_controller;

  localparam int CODE_LEN  = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYC  = 8;

  logic clk;
  logic rst_n;

  combo_lock_controller_if #(.CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES)) bus ();

  combo_lock_controller #(
    .CODE_LEN       (CODE_LEN),
    .INIT_CODE      (8'b11100100),
    .MAX_TRIES      (MAX_TRIES),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int ul, input int er,
                            input int lo, input int dc, input int tl);
    chk({tag, ".unlocked"},    int'(bus.unlocked),    ul);
    chk({tag, ".error"},       int'(bus.error),       er);
    chk({tag, ".locked_out"},  int'(bus.locked_out),  lo);
    chk({tag, ".digit_count"}, int'(bus.digit_count), dc);
    chk({tag, ".tries_left"},  int'(bus.tries_left),  tl);
  endtask

  // ---------------- reference model: sequences, not states ----------------
  int m_code[CODE_LEN];
  int m_ent[$];     // digits entered so far (-1 = multi-key press)
  int m_prg[$];     // digits programmed so far
  bit m_open, m_prog, m_fail;
  int m_lock;       // lockout cycles still to serve
  int m_tries;

  function automatic void m_reset();
    logic [7:0] init_code;
    init_code = 8'b11100100;
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'(init_code[2*i +: 2]);
    m_ent.delete();
    m_prg.delete();
    m_open  = 0;
    m_prog  = 0;
    m_fail  = 0;
    m_lock  = 0;
    m_tries = MAX_TRIES;
  endfunction

  function automatic void model_step(input logic [3:0] k, input bit r, input bit p);
    int n;
    int idx;
    bit ok;
    n   = $countones(k);
    idx = 0;
    for (int i = 0; i < 4; i++) if (k[i]) idx = i;
    if (m_fail) begin
      m_fail = 0;
      if (m_tries <= 1) m_lock = LOCK_CYC;
      if (m_tries > 0) m_tries--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = MAX_TRIES;
    end else if (m_prog) begin
      if (r) begin
        m_prog = 0; m_open = 0; m_prg.delete();
      end else if (!p) begin
        m_prog = 0; m_prg.delete();
      end else if (n == 1) begin
        m_prg.push_back(idx);
        if (m_prg.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prg[i];
          m_prog = 0;
          m_prg.delete();
        end
      end
    end else if (m_open) begin
      if (r) m_open = 0;
      else if (n == 1 && p) begin
        m_prog = 1;
        m_prg.push_back(idx);
      end
    end else begin
      if (r) m_ent.delete();
      else if (n > 0) begin
        m_ent.push_back((n == 1) ? idx : -1);
        if (m_ent.size() == CODE_LEN) begin
          ok = 1;
          for (int i = 0; i < CODE_LEN; i++) if (m_ent[i] != m_code[i]) ok = 0;
          if (ok) begin
            m_open  = 1;
            m_tries = MAX_TRIES;
          end else begin
            m_fail = 1;
          end
          m_ent.delete();
        end
      end
    end
  endfunction

  task automatic model_check(input string tag);
    check_outs(tag, int'(m_open), int'(m_fail), int'(m_lock > 0),
               m_prog ? m_prg.size() : m_ent.size(), m_tries);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input logic [3:0] k, input bit r, input bit p);
    bus.key_pulse = k;
    bus.relock    = r;
    bus.prog_en   = p;
    @(posedge clk);
    model_step(k, r, p);
    #1;
  endtask

  function automatic logic [3:0] key(input int idx);
    return 4'(1 << idx);
  endfunction

  task automatic enter(input int d0, input int d1, input int d2, input int d3, input bit p);
    cyc(key(d0), 0, p);
    cyc(key(d1), 0, p);
    cyc(key(d2), 0, p);
    cyc(key(d3), 0, p);
  endtask

  task automatic do_reset(input string tag);
    bus.key_pulse = '0;
    bus.relock    = 1'b0;
    bus.prog_en   = 1'b0;
    rst_n = 1'b0;
    #2;
    m_reset();
    check_outs(tag, 0, 0, 0, 0, MAX_TRIES);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] k;
    bit         r;
    bit         p;
    int         ul, er, lo, dc, tl;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] k, input bit r, input bit p,
                              input int ul, input int er, input int lo,
                              input int dc, input int tl);
    vec_t v;
    v.k = k; v.r = r; v.p = p;
    v.ul = ul; v.er = er; v.lo = lo; v.dc = dc; v.tl = tl;
    return v;
  endfunction

  vec_t vecs[$];
  int   lo_cnt;
  bit   pe;
  logic [3:0] rk;
  bit   rr;
  int   roll;

  initial begin
    bus.key_pulse = '0;
    bus.relock    = 1'b0;
    bus.prog_en   = 1'b0;
    rst_n         = 1'b1;
    #3;
    do_reset("reset");

    // correct code, relock, wrong code, retry, relock+key precedence
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 2, 3));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 3, 3));
    vecs.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 2, 3));
    vecs.push_back(mk(4'b1000, 0, 0, 0, 0, 0, 3, 3));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 1, 0, 0, 3));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(4'b0100, 0, 0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(4'b0010, 1, 0, 0, 0, 0, 0, 3));
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].k, vecs[i].r, vecs[i].p);
      check_outs($sformatf("vec%0d", i), vecs[i].ul, vecs[i].er, vecs[i].lo,
                 vecs[i].dc, vecs[i].tl);
    end

    // three wrong attempts -> lockout of exactly LOCK_CYC cycles, inputs ignored
    for (int a = 0; a < 3; a++) begin
      enter(0, 0, 0, 0, 0);
      chk($sformatf("t3.error%0d", a), int'(bus.error), 1);
      chk($sformatf("t3.tries_in_fail%0d", a), int'(bus.tries_left), 3 - a);
      if (a < 2) begin
        cyc(4'b0000, 0, 0);
        chk($sformatf("t3.tries%0d", a), int'(bus.tries_left), 2 - a);
        chk($sformatf("t3.not_locked%0d", a), int'(bus.locked_out), 0);
      end
    end
    lo_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      cyc(4'b0001, j[0], 0);
      chk("t3.lock_digits", int'(bus.digit_count), 0);
      if (bus.locked_out) lo_cnt++;
      else break;
    end
    chk("t3.lockout_len", lo_cnt, LOCK_CYC);
    chk("t3.tries_reload", int'(bus.tries_left), 3);
    enter(0, 1, 2, 3, 0);
    chk("t3.opens", int'(bus.unlocked), 1);

    // programming a new code 3,3,0,1
    cyc(4'b0000, 0, 1);
    check_outs("t4.open_idle", 1, 0, 0, 0, 3);
    cyc(key(3), 0, 1);
    check_outs("t4.prog1", 1, 0, 0, 1, 3);
    cyc(key(3), 0, 1);
    chk("t4.prog2.dc", int'(bus.digit_count), 2);
    cyc(key(0), 0, 1);
    chk("t4.prog3.dc", int'(bus.digit_count), 3);
    cyc(key(1), 0, 1);
    check_outs("t4.prog_done", 1, 0, 0, 0, 3);
    cyc(4'b0000, 1, 0);
    chk("t4.relock", int'(bus.unlocked), 0);
    enter(3, 3, 0, 1, 0);
    chk("t4.new_opens", int'(bus.unlocked), 1);
    cyc(4'b0000, 1, 0);
    enter(0, 1, 2, 3, 0);
    chk("t4.old_rejected", int'(bus.error), 1);
    cyc(4'b0000, 0, 0);
    chk("t4.tries", int'(bus.tries_left), 2);

    // aborted programming keeps the code; multi-key press forces mismatch
    enter(3, 3, 0, 1, 0);
    chk("t5.open", int'(bus.unlocked), 1);
    cyc(key(0), 0, 1);
    cyc(key(0), 0, 1);
    chk("t5.prog_dc", int'(bus.digit_count), 2);
    cyc(4'b0000, 1, 1);
    check_outs("t5.abort", 0, 0, 0, 0, 3);
    enter(3, 3, 0, 1, 0);
    chk("t5.code_kept", int'(bus.unlocked), 1);
    cyc(4'b0000, 1, 0);
    cyc(key(3), 0, 0);
    cyc(4'b0011, 0, 0);
    chk("t5.multi_counts", int'(bus.digit_count), 2);
    cyc(key(0), 0, 0);
    cyc(key(1), 0, 0);
    check_outs("t5.multi_error", 0, 1, 0, 0, 3);
    cyc(4'b0000, 0, 0);

    // reset mid-entry, mid-lockout, and after programming
    cyc(key(3), 0, 0);
    cyc(key(3), 0, 0);
    do_reset("t6.mid_entry");
    for (int a = 0; a < 3; a++) begin
      enter(0, 0, 0, 0, 0);
      cyc(4'b0000, 0, 0);
    end
    chk("t6.locked", int'(bus.locked_out), 1);
    cyc(4'b0000, 0, 0);
    cyc(4'b0000, 0, 0);
    do_reset("t6.mid_lockout");
    cyc(4'b0000, 0, 0);
    check_outs("t6.after_lock_reset", 0, 0, 0, 0, 3);
    enter(0, 1, 2, 3, 0);
    enter(2, 2, 2, 2, 1);
    check_outs("t6.programmed", 1, 0, 0, 0, 3);
    cyc(4'b0000, 1, 0);
    do_reset("t6.after_prog");
    enter(2, 2, 2, 2, 0);
    chk("t6.prog_discarded", int'(bus.error), 1);
    cyc(4'b0000, 0, 0);
    enter(0, 1, 2, 3, 0);
    chk("t6.init_restored", int'(bus.unlocked), 1);
    model_check("t6.model_sync");

    // randomized traffic against the model
    pe = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 4) pe = !pe;
      rr   = ($urandom_range(0, 99) < 3);
      roll = int'($urandom_range(0, 99));
      if (roll < 40) rk = 4'b0000;
      else if (roll < 48) rk = 4'($urandom_range(0, 15));
      else if (roll < 80 && !m_open && !m_prog && m_ent.size() < CODE_LEN)
        rk = key(m_code[m_ent.size()]);
      else rk = key(int'($urandom_range(0, 3)));
      cyc(rk, rr, pe);
      model_check($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
